// File: rtl/dcp_port_dispatch_pkg.sv
// Shared definitions for the DCP port dispatcher: FSM encoding, FDB code widths
// and the saturating counter helper.
package dcp_port_dispatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOOKUP   = 2'd1,
      ST_DISPATCH = 2'd2
   } dcp_state_e;

   localparam int               DCP_PORT_W       = 5;
   localparam logic [4:0]       DCP_PORT_UNKNOWN = 5'd0;
   localparam int               DCP_MAC_W        = 48;

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : (val + 16'd1);
   endfunction

endpackage

// File: rtl/dcp_desc_fifo.sv
// Per-port descriptor FIFO: circular buffer with a separate occupancy count and
// a combinational head read.
module dcp_desc_fifo #(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] din,
   input  logic              pop,
   output logic [ADDR_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   // Full refuses pushes even with a same-edge pop; empty ignores pops.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign empty     = (count_r == CNT_W'(0));
   assign full      = (count_r == CNT_W'(FIFO_DEPTH));
   assign dout      = mem_r[rd_ptr_r];

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/dcp_port_dispatch.sv
// DCP port dispatcher: accepts a descriptor, queries the FDB and pushes the
// buffer address into one port FIFO (unicast) or all of them (flood).
module dcp_port_dispatch
   import dcp_port_dispatch_pkg::*;
#(
   parameter int NUM_PORTS  = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        desc_valid_i,
   output logic                        desc_ready_o,
   input  logic [DCP_MAC_W-1:0]        dmac_i,
   input  logic [ADDR_W-1:0]           start_addr_i,
   output logic [DCP_MAC_W-1:0]        fdb_dmac_o,
   input  logic [DCP_PORT_W-1:0]       fdb_port_i,
   input  logic [NUM_PORTS-1:0]        port_rd_i,
   output logic [NUM_PORTS-1:0]        port_valid_o,
   output logic [NUM_PORTS*ADDR_W-1:0] port_addr_o,
   output logic [15:0]                 fwd_cnt_o,
   output logic [15:0]                 flood_cnt_o
);

   dcp_state_e             state_r;
   dcp_state_e             state_s;
   logic                   ready_r;
   logic [DCP_MAC_W-1:0]   dmac_r;
   logic [ADDR_W-1:0]      addr_r;
   logic [15:0]            fwd_cnt_r;
   logic [15:0]            flood_cnt_r;

   logic                   accept_s;
   logic                   fwd_inc_s;
   logic                   flood_inc_s;
   logic [NUM_PORTS-1:0]   hit_s;
   logic                   code_known_s;
   logic [NUM_PORTS-1:0]   push_s;
   logic [NUM_PORTS-1:0]   fifo_full_s;
   logic [NUM_PORTS-1:0]   fifo_empty_s;

   // One-hot decode of the FDB code; unknown and out-of-range codes decode to zero.
   always_comb begin
      hit_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         hit_s[p] = (fdb_port_i == DCP_PORT_W'(p + 1));
      end
   end

   assign code_known_s = (fdb_port_i != DCP_PORT_UNKNOWN) && (|hit_s);

   // Next-state, push-enable and counter-increment decode.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      fwd_inc_s   = 1'b0;
      flood_inc_s = 1'b0;
      push_s      = '0;
      case (state_r)
         ST_IDLE: begin
            if (desc_valid_i) begin
               accept_s = 1'b1;
               state_s  = ST_LOOKUP;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            state_s = ST_DISPATCH;
         end
         ST_DISPATCH: begin
            if (code_known_s) begin
               if (|(hit_s & ~fifo_full_s)) begin
                  push_s    = hit_s;
                  fwd_inc_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  state_s   = ST_DISPATCH;
               end
            end else begin
               // Flood is all-or-nothing: wait until every FIFO has room.
               if (~|fifo_full_s) begin
                  push_s      = '1;
                  flood_inc_s = 1'b1;
                  state_s     = ST_IDLE;
               end else begin
                  state_s     = ST_DISPATCH;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, registered ready, descriptor latch and saturating counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         ready_r     <= 1'b1;
         dmac_r      <= '0;
         addr_r      <= '0;
         fwd_cnt_r   <= 16'd0;
         flood_cnt_r <= 16'd0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == ST_IDLE);
         if (accept_s) begin
            dmac_r <= dmac_i;
            addr_r <= start_addr_i;
         end
         if (fwd_inc_s) begin
            fwd_cnt_r <= sat_inc16(fwd_cnt_r);
         end
         if (flood_inc_s) begin
            flood_cnt_r <= sat_inc16(flood_cnt_r);
         end
      end
   end

   assign desc_ready_o = ready_r;
   assign fdb_dmac_o   = dmac_r;
   assign fwd_cnt_o    = fwd_cnt_r;
   assign flood_cnt_o  = flood_cnt_r;
   assign port_valid_o = ~fifo_empty_s;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_fifo
      dcp_desc_fifo #(
         .ADDR_W     (ADDR_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push_s[g]),
         .din   (addr_r),
         .pop   (port_rd_i[g]),
         .dout  (port_addr_o[g*ADDR_W +: ADDR_W]),
         .empty (fifo_empty_s[g]),
         .full  (fifo_full_s[g])
      );
   end

endmodule

// File: tb/tb_dcp_port_dispatch.sv
// Randomized bench for dcp_port_dispatch against a queue-based reference model,
// with directed scenarios pinning latency, flood, backpressure, wrap, reset and saturation.
module tb_dcp_port_dispatch;

   localparam int NP    = 6;
   localparam int DEPTH = 4;
   localparam int AW    = 16;

   logic              clk;
   logic              reset;
   logic              desc_valid_i;
   logic              desc_ready_o;
   logic [47:0]       dmac_i;
   logic [AW-1:0]     start_addr_i;
   logic [47:0]       fdb_dmac_o;
   logic [4:0]        fdb_port_i;
   logic [NP-1:0]     port_rd_i;
   logic [NP-1:0]     port_valid_o;
   logic [NP*AW-1:0]  port_addr_o;
   logic [15:0]       fwd_cnt_o;
   logic [15:0]       flood_cnt_o;

   dcp_port_dispatch #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .desc_valid_i (desc_valid_i),
      .desc_ready_o (desc_ready_o),
      .dmac_i       (dmac_i),
      .start_addr_i (start_addr_i),
      .fdb_dmac_o   (fdb_dmac_o),
      .fdb_port_i   (fdb_port_i),
      .port_rd_i    (port_rd_i),
      .port_valid_o (port_valid_o),
      .port_addr_o  (port_addr_o),
      .fwd_cnt_o    (fwd_cnt_o),
      .flood_cnt_o  (flood_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Reference model: per-port queues plus the pending descriptor and its age.
   logic [AW-1:0] mq [NP][$];
   int            m_stage;      // 0 waiting, 1 looking up, 2 dispatching
   logic [AW-1:0] m_addr;
   logic [4:0]    m_code;
   logic [47:0]   m_dmac;
   logic [15:0]   m_fwd;
   logic [15:0]   m_flood;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_stage = 0;
      m_addr  = '0;
      m_code  = '0;
      m_dmac  = '0;
      m_fwd   = 16'd0;
      m_flood = 16'd0;
   endtask

   task automatic model_step(input logic v, input logic [47:0] mac, input logic [AW-1:0] a,
                             input logic [4:0] code, input logic [NP-1:0] rd);
      bit full_pre [NP];
      bit any_full;
      any_full = 1'b0;
      for (int p = 0; p < NP; p++) begin
         full_pre[p] = (mq[p].size() == DEPTH);
         if (full_pre[p]) any_full = 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
         if (rd[p] && mq[p].size() > 0) void'(mq[p].pop_front());
      end
      if (m_stage == 0) begin
         if (v) begin
            m_stage = 1;
            m_addr  = a;
            m_code  = code;
            m_dmac  = mac;
         end
      end else if (m_stage == 1) begin
         m_stage = 2;
      end else begin
         if (m_code >= 5'd1 && m_code <= 5'(NP)) begin
            if (!full_pre[int'(m_code) - 1]) begin
               mq[int'(m_code) - 1].push_back(m_addr);
               if (m_fwd != 16'hFFFF) m_fwd = m_fwd + 16'd1;
               m_stage = 0;
            end
         end else if (!any_full) begin
            for (int p = 0; p < NP; p++) mq[p].push_back(m_addr);
            if (m_flood != 16'hFFFF) m_flood = m_flood + 16'd1;
            m_stage = 0;
         end
      end
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", 64'(desc_ready_o), 64'(m_stage == 0));
         check("fdb_dmac", 64'(fdb_dmac_o), 64'(m_dmac));
         check("fwd_cnt", 64'(fwd_cnt_o), 64'(m_fwd));
         check("flood_cnt", 64'(flood_cnt_o), 64'(m_flood));
         for (int p = 0; p < NP; p++) begin
            check("port_valid", 64'(port_valid_o[p]), 64'(mq[p].size() > 0));
            if (mq[p].size() > 0) check("port_head", 64'(port_addr_o[p*AW +: AW]), 64'(mq[p][0]));
         end
      end
   end

   // One clock: drive inputs, step the model at the edge, return just after the next falling edge.
   task automatic drive_cycle(input logic v, input logic [47:0] mac, input logic [AW-1:0] a,
                              input logic [4:0] code, input logic [NP-1:0] rd);
      desc_valid_i = v;
      dmac_i       = mac;
      start_addr_i = a;
      port_rd_i    = rd;
      fdb_port_i   = (m_stage == 2) ? m_code : 5'($urandom);
      @(posedge clk);
      model_step(v, mac, a, code, rd);
      @(negedge clk);
      #2;
   endtask

   task automatic idle(input logic [NP-1:0] rd);
      drive_cycle(1'b0, 48'h0, 16'h0, 5'd0, rd);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 64'(desc_ready_o), 64'd1);
      check("rst_valid", 64'(port_valid_o), 64'd0);
      check("rst_addr", 64'(port_addr_o[63:0]), 64'd0);
      check("rst_addr_hi", 64'(port_addr_o[NP*AW-1:64]), 64'd0);
      check("rst_fdb_dmac", 64'(fdb_dmac_o), 64'd0);
      check("rst_fwd", 64'(fwd_cnt_o), 64'd0);
      check("rst_flood", 64'(flood_cnt_o), 64'd0);
   endtask

   initial begin
      logic [4:0] code;
      int         r;
      reset        = 1'b0;
      desc_valid_i = 1'b0;
      dmac_i       = 48'h0;
      start_addr_i = 16'h0;
      fdb_port_i   = 5'd0;
      port_rd_i    = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs();
      reset  = 1'b1;
      chk_en = 1'b1;

      // Unicast to port 0: visible after the third edge.
      drive_cycle(1'b1, 48'haa2030405060, 16'h0100, 5'd1, '0);
      check("t1_ready_low", 64'(desc_ready_o), 64'd0);
      check("t1_fdb_key", 64'(fdb_dmac_o), 64'haa2030405060);
      idle('0);
      check("t1_not_yet", 64'(port_valid_o), 64'd0);
      idle('0);
      check("t1_valid", 64'(port_valid_o), 64'h01);
      check("t1_head", 64'(port_addr_o[15:0]), 64'h0100);
      check("t1_fwd", 64'(fwd_cnt_o), 64'd1);

      // Flood with port 0 drained on the accept edge.
      drive_cycle(1'b1, 48'h0102_0304_0506, 16'h0200, 5'd0, 6'b000001);
      idle('0);
      idle('0);
      check("t2_valid", 64'(port_valid_o), 64'h3F);
      for (int p = 0; p < NP; p++) check("t2_head", 64'(port_addr_o[p*AW +: AW]), 64'h0200);
      check("t2_flood", 64'(flood_cnt_o), 64'd1);
      idle(6'h3F);

      // Backpressure on port index 2.
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b1, 48'h0000_0000_0300, 16'(16'h0300 + i), 5'd3, '0);
         idle('0);
         idle('0);
      end
      drive_cycle(1'b1, 48'h0000_0000_0304, 16'h0304, 5'd3, '0);
      idle('0);
      idle('0);
      idle('0);
      check("t3_blocked", 64'(desc_ready_o), 64'd0);
      idle(6'b000100);
      check("t3_still_blocked", 64'(desc_ready_o), 64'd0);
      idle('0);
      check("t3_released", 64'(desc_ready_o), 64'd1);
      check("t3_head", 64'(port_addr_o[2*AW +: AW]), 64'h0301);
      check("t3_fwd", 64'(fwd_cnt_o), 64'd6);

      // Flood blocked by full port 2, then asynchronous reset mid-dispatch.
      drive_cycle(1'b1, 48'h0000_0000_0500, 16'h0500, 5'd0, '0);
      idle('0);
      idle('0);
      check("t5_blocked", 64'(desc_ready_o), 64'd0);
      reset = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      idle('0);
      check("t5_empty", 64'(port_valid_o), 64'd0);
      check("t5_ready", 64'(desc_ready_o), 64'd1);

      // Same-edge push and pop on port index 1, then wrap through 9 pairs.
      drive_cycle(1'b1, 48'h0000_0000_0600, 16'h0600, 5'd2, '0);
      idle('0);
      idle('0);
      drive_cycle(1'b1, 48'h0000_0000_0601, 16'h0601, 5'd2, '0);
      idle('0);
      idle(6'b000010);
      check("t4_valid", 64'(port_valid_o[1]), 64'd1);
      check("t4_head", 64'(port_addr_o[AW +: AW]), 64'h0601);
      for (int i = 0; i < 9; i++) begin
         drive_cycle(1'b1, 48'h0000_0000_0700, 16'(16'h0700 + i), 5'd2, '0);
         idle('0);
         idle(6'b000010);
      end
      check("t4_wrap_head", 64'(port_addr_o[AW +: AW]), 64'h0708);
      idle(6'b000010);
      check("t4_drained", 64'(port_valid_o[1]), 64'd0);

      // Forward counter saturation.
      force dut.fwd_cnt_r = 16'hFFFE;
      #1;
      release dut.fwd_cnt_r;
      m_fwd = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 48'h0000_0000_0800, 16'(16'h0800 + i), 5'd4, 6'b001000);
         idle(6'b001000);
         idle(6'b001000);
      end
      check("t6_sat", 64'(fwd_cnt_o), 64'hFFFF);

      // Randomized traffic including unknown and out-of-range FDB codes.
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 7)      code = 5'(r);
         else if (r == 8) code = 5'd31;
         else             code = 5'd15;
         drive_cycle(1'($urandom_range(0, 1)), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                     16'($urandom), code, NP'($urandom & $urandom));
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
